mdu_iter: RTL and testbench

- Parametrised multi-cycle multiply/divide unit holding the architectural HI/LO register pair.
- Sits in the EX stage beside the combinational ALU.
- The pipeline control stalls any HI/LO-touching instruction in ID while `busy` or `start` is high.
- Successor to the single-cycle ALU: width, multiply latency and divide latency are generic, and results are committed after a countdown instead of in the issue cycle.

---
 rtl/mdu_pkg.sv | 20 ++
 rtl/mdu_iter.sv | 162 ++++++++++++++++
 tb/tb_mdu_iter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding,
// control state type and op field width.
package mdu_pkg;

  localparam int MDU_OP_W = 3;

  localparam logic [MDU_OP_W-1:0] MDU_NONE  = 3'd0;
  localparam logic [MDU_OP_W-1:0] MDU_MULT  = 3'd1;
  localparam logic [MDU_OP_W-1:0] MDU_MULTU = 3'd2;
  localparam logic [MDU_OP_W-1:0] MDU_DIV   = 3'd3;
  localparam logic [MDU_OP_W-1:0] MDU_DIVU  = 3'd4;
  localparam logic [MDU_OP_W-1:0] MDU_MTHI  = 3'd5;
  localparam logic [MDU_OP_W-1:0] MDU_MTLO  = 3'd6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair. Results are computed
// at issue, held in pending registers, and committed after a fixed countdown.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10,
  parameter int CNT_W      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [MDU_OP_W-1:0] op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic                busy,
  output logic [WIDTH-1:0]    hi,
  output logic [WIDTH-1:0]    lo,
  output logic                div_by_zero
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MINUS_1  = {WIDTH{1'b1}};

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             dz_pulse_q, dz_pulse_d;

  // Arithmetic results, evaluated every cycle and only used at issue.
  logic signed [2*WIDTH-1:0] prod_s;
  logic        [2*WIDTH-1:0] prod_u;
  logic        [WIDTH-1:0]   quo_s, rem_s, quo_u, rem_u;

  always_comb begin
    prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    quo_s  = '0;
    rem_s  = '0;
    quo_u  = '0;
    rem_u  = '0;
    // A zero divisor never commits, so its quotient is left at zero rather
    // than letting the divider produce an undefined value.
    if (b != '0) begin
      quo_u = a / b;
      rem_u = a % b;
      if (a == MOST_NEG && b == MINUS_1) begin
        quo_s = MOST_NEG;
        rem_s = '0;
      end else begin
        quo_s = WIDTH'($signed(a) / $signed(b));
        rem_s = WIDTH'($signed(a) % $signed(b));
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_hi_d  = pend_hi_q;
    pend_lo_d  = pend_lo_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dz_pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            MDU_MULT: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              cnt_d   = MUL_LOAD;
              dz_d    = 1'b0;
              state_d = RUN;
            end
            MDU_MULTU: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              cnt_d   = MUL_LOAD;
              dz_d    = 1'b0;
              state_d = RUN;
            end
            MDU_DIV: begin
              pend_lo_d = quo_s;
              pend_hi_d = rem_s;
              cnt_d     = DIV_LOAD;
              dz_d      = (b == '0);
              state_d   = RUN;
            end
            MDU_DIVU: begin
              pend_lo_d = quo_u;
              pend_hi_d = rem_u;
              cnt_d     = DIV_LOAD;
              dz_d      = (b == '0);
              state_d   = RUN;
            end
            MDU_MTHI: hi_d = a;
            MDU_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          if (dz_q) begin
            dz_pulse_d = 1'b1;
          end else begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_hi_q  <= '0;
      pend_lo_q  <= '0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      dz_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_hi_q  <= pend_hi_d;
      pend_lo_q  <= pend_lo_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      dz_pulse_q <= dz_pulse_d;
    end
  end

  assign busy        = busy_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dz_pulse_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed cases plus randomized ops scored
// against a plain-arithmetic HI/LO model.
module tb_mdu_iter;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start1;
  logic [2:0]  op, op1;
  logic [31:0] a, b, a1, b1;
  logic        busy, busy1;
  logic [31:0] hi, lo, hi1, lo1;
  logic        dz, dz1;

  int n_cmp = 0;
  int n_bad = 0;
  logic        allow_viol = 1'b0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  always #5 clk = ~clk;

  mdu_iter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo), .div_by_zero(dz)
  );

  mdu_iter #(.WIDTH(32), .MUL_CYCLES(1), .DIV_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .a(a1), .b(b1),
    .busy(busy1), .hi(hi1), .lo(lo1), .div_by_zero(dz1)
  );

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(start && busy) || allow_viol)
        else $error("protocol violation: start while busy");
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
    end
  endtask

  // Architectural effect of one issued op on {hi,lo}, and its busy length.
  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] nh, output logic [31:0] nl,
                       output logic ndz, output int n);
    longint p;
    nh = exp_hi; nl = exp_lo; ndz = 1'b0; n = 0;
    case (o)
      MDU_MULT: begin
        p = longint'(int'(x)) * longint'(int'(y));
        {nh, nl} = p; n = 5;
      end
      MDU_MULTU: begin
        p = longint'({32'd0, x}) * longint'({32'd0, y});
        {nh, nl} = p; n = 5;
      end
      MDU_DIV: begin
        n = 10;
        if (y == 0) ndz = 1'b1;
        else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          nl = 32'h8000_0000; nh = 0;
        end else begin
          nl = int'(x) / int'(y); nh = int'(x) % int'(y);
        end
      end
      MDU_DIVU: begin
        n = 10;
        if (y == 0) ndz = 1'b1;
        else begin nl = x / y; nh = x % y; end
      end
      MDU_MTHI: nh = x;
      MDU_MTLO: nl = x;
      default: ;
    endcase
  endtask

  // Called at a negedge; returns at the negedge after the result is visible.
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] nh, nl;
    logic ndz;
    int n;
    model(o, x, y, nh, nl, ndz, n);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = MDU_NONE;
    for (int i = 0; i < n; i++) begin
      check("busy_run", {31'd0, busy}, 32'd1);
      check("hi_hold", hi, exp_hi);
      check("lo_hold", lo, exp_lo);
      @(negedge clk);
    end
    check("busy_done", {31'd0, busy}, 32'd0);
    check("hi_res", hi, nh);
    check("lo_res", lo, nl);
    check("dz_pulse", {31'd0, dz}, {31'd0, ndz});
    exp_hi = nh; exp_lo = nl;
    if (ndz) begin
      @(negedge clk);
      check("dz_clear", {31'd0, dz}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] nh, nl;
    logic ndz;
    int n;
    logic [2:0] ro;
    logic [31:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    start1 = 1'b0; op1 = '0; a1 = '0; b1 = '0;
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_dz", {31'd0, dz}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(MDU_MULT,  32'hFFFF_FFFE, 32'd3);
    do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
    do_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2);
    do_op(MDU_DIVU,  32'd7,         32'd0);
    do_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    do_op(MDU_DIV,   32'd7,         32'hFFFF_FFFE);
    do_op(MDU_MTHI,  32'h1234_5678, 32'd0);
    do_op(MDU_NONE,  32'hAAAA_AAAA, 32'd1);
    do_op(3'd7,      32'h5555_5555, 32'd1);

    // MTLO arriving while a MULT is in flight must be dropped.
    model(MDU_MULT, 32'd6, 32'd7, nh, nl, ndz, n);
    start = 1'b1; op = MDU_MULT; a = 32'd6; b = 32'd7;
    @(negedge clk);
    allow_viol = 1'b1;
    op = MDU_MTLO; a = 32'hDEAD_BEEF;
    check("busy_viol", {31'd0, busy}, 32'd1);
    @(negedge clk);
    start = 1'b0; allow_viol = 1'b0; op = MDU_NONE;
    for (int i = 0; i < 4; i++) begin
      check("lo_hold_viol", lo, exp_lo);
      @(negedge clk);
    end
    check("hi_viol", hi, nh);
    check("lo_viol", lo, nl);
    exp_hi = nh; exp_lo = nl;

    // Reset during a divide aborts it.
    do_op(MDU_MTLO, 32'hCAFE_F00D, 32'd0);
    start = 1'b1; op = MDU_DIV; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0; op = MDU_NONE;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    exp_hi = '0; exp_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    do_op(MDU_MULT, 32'd3, 32'd4);

    // Back-to-back issue on the single-cycle instance.
    start1 = 1'b1; op1 = MDU_MULT; a1 = 32'd2; b1 = 32'd2;
    @(negedge clk);
    start1 = 1'b0;
    check("fast_busy1", {31'd0, busy1}, 32'd1);
    @(negedge clk);
    check("fast_idle1", {31'd0, busy1}, 32'd0);
    check("fast_lo1", lo1, 32'd4);
    start1 = 1'b1; op1 = MDU_MULT; a1 = 32'd3; b1 = 32'd3;
    @(negedge clk);
    start1 = 1'b0;
    check("fast_busy2", {31'd0, busy1}, 32'd1);
    @(negedge clk);
    check("fast_idle2", {31'd0, busy1}, 32'd0);
    check("fast_lo2", lo1, 32'd9);
    check("fast_hi2", hi1, 32'd0);
    start1 = 1'b1; op1 = MDU_DIVU; a1 = 32'd5; b1 = 32'd0;
    @(negedge clk);
    start1 = 1'b0;
    @(negedge clk);
    check("fast_dz", {31'd0, dz1}, 32'd1);
    check("fast_dz_lo", lo1, 32'd9);
    @(negedge clk);
    check("fast_dz_clr", {31'd0, dz1}, 32'd0);

    // Randomized ops with occasional corner operands.
    for (int k = 0; k < 60; k++) begin
      ro = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       ra = $urandom;
        1:       ra = 32'($urandom_range(0, 40)) - 32'd20;
        2:       ra = 32'h8000_0000;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($urandom_range(0, 16)) - 32'd8;
        default: rb = $urandom;
      endcase
      do_op(ro, ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
